// File: rtl/fifoc_cmd_parser_if.sv
// rtl/fifoc_cmd_parser_if.sv - command FIFO read port between the parser (master) and the FIFO (slave)
interface fifoc_cmd_parser_if;
    logic       fifoc_empty;
    logic       fifoc_rxen;
    logic [7:0] fifoc_rxd;

    modport master (
        output fifoc_rxen,
        input  fifoc_empty,
        input  fifoc_rxd
    );

    modport slave (
        input  fifoc_rxen,
        output fifoc_empty,
        output fifoc_rxd
    );
endinterface

// File: rtl/fifoc_cmd_parser.sv
// rtl/fifoc_cmd_parser.sv - parses HEAD0/HEAD1/payload/checksum frames from the command FIFO into cmd_regs
module fifoc_cmd_parser #(
    parameter int         NUM_REG = 9,
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fs,
    output logic                  fd,
    fifoc_cmd_parser_if.master    fifo,
    output logic [NUM_REG*8-1:0]  cmd_regs,
    output logic                  cmd_upd,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int              CW        = $clog2(NUM_REG + 1);
    localparam logic [15:0]     TMO_LIMIT = 16'(TIMEOUT);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(NUM_REG - 1);

    typedef enum logic [2:0] {IDLE, HEAD, DATA, CSUM, DONE} state_t;

    state_t               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           acc_q, acc_d;
    logic [15:0]          tmo_q, tmo_d;
    logic [NUM_REG*8-1:0] shadow_q, shadow_d;
    logic [NUM_REG*8-1:0] regs_q, regs_d;
    logic                 upd_q, upd_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 rd_en;
    logic [15:0]          tmo_next;
    logic [7:0]           head_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= 8'd0;
            tmo_q      <= 16'd0;
            shadow_q   <= '0;
            regs_q     <= '0;
            upd_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            shadow_q   <= shadow_d;
            regs_q     <= regs_d;
            upd_q      <= upd_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        shadow_d   = shadow_q;
        regs_d     = regs_q;
        upd_d      = 1'b0;
        err_code_d = err_code_q;
        rd_en      = 1'b0;
        tmo_next   = tmo_q + 16'd1;
        head_exp   = (cnt_q == '0) ? HEAD0 : HEAD1;

        if (state_q == IDLE) begin
            if (fs) begin
                state_d    = HEAD;
                cnt_d      = '0;
                acc_d      = 8'd0;
                tmo_d      = 16'd0;
                err_code_d = 2'd0;
            end
        end else if (state_q == DONE) begin
            if (!fs) begin
                state_d = IDLE;
            end
        end else if (pend_q) begin
            // A read issued last cycle returns its byte now.
            tmo_d = 16'd0;
            case (state_q)
                HEAD: begin
                    if (fifo.fifoc_rxd != head_exp) begin
                        err_code_d = 2'd1;
                        state_d    = DONE;
                    end else if (cnt_q != '0) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    shadow_d[8*int'(cnt_q) +: 8] = fifo.fifoc_rxd;
                    acc_d = acc_q + fifo.fifoc_rxd;
                    if (cnt_q == LAST_IDX) begin
                        state_d = CSUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CSUM: begin
                    if (fifo.fifoc_rxd == acc_q) begin
                        regs_d     = shadow_q;
                        upd_d      = 1'b1;
                        err_code_d = 2'd0;
                    end else begin
                        err_code_d = 2'd2;
                    end
                    state_d = DONE;
                end
                default: ;
            endcase
        end else begin
            tmo_d = tmo_next;
            if (tmo_next == TMO_LIMIT) begin
                err_code_d = 2'd3;
                state_d    = DONE;
            end else begin
                rd_en = !fifo.fifoc_empty && !rst;
            end
        end

        pend_d = rd_en;
    end

    assign fifo.fifoc_rxen = rd_en;
    assign fd              = (state_q == DONE);
    assign err             = fd && (err_code_q != 2'd0);
    assign err_code        = err_code_q;
    assign cmd_regs        = regs_q;
    assign cmd_upd         = upd_q;
endmodule

// File: tb/tb_fifoc_cmd_parser.sv
// tb/tb_fifoc_cmd_parser.sv - directed self-checking bench for fifoc_cmd_parser
module tb_fifoc_cmd_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic [71:0] cmd_regs;
    logic        cmd_upd;
    logic        err;
    logic [1:0]  err_code;
    logic        stall;

    fifoc_cmd_parser_if bus ();

    fifoc_cmd_parser #(
        .NUM_REG (9),
        .HEAD0   (8'h55),
        .HEAD1   (8'hAA),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fs       (fs),
        .fd       (fd),
        .fifo     (bus.master),
        .cmd_regs (cmd_regs),
        .cmd_upd  (cmd_upd),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int reads = 0;
    int upd_cnt = 0;
    int viol = 0;
    int cyc = 0;
    int last_rd_cyc = 0;
    int fd_cyc = 0;
    logic fd_prev = 1'b0;
    int checks = 0;
    int failures = 0;
    int rb;
    int ub;

    assign bus.fifoc_empty = stall || (rd_ptr == wr_ptr);

    // FIFO model: data appears one cycle after a read enable.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.fifoc_rxen) begin
            if (bus.fifoc_empty) viol = viol + 1;
            bus.fifoc_rxd <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
            reads = reads + 1;
            last_rd_cyc = cyc;
        end
        if (cmd_upd) upd_cnt = upd_cnt + 1;
        if (fd && !fd_prev) fd_cyc = cyc;
        fd_prev = fd;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        chk(tag, 72'(obs), 72'(exp));
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_payload(input logic [7:0] first, input logic [7:0] csum);
        for (int i = 0; i < 9; i++) push(first + 8'(i));
        push(csum);
    endtask

    task automatic wait_fd(input string tag);
        for (int i = 0; i < 300 && fd !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chki(tag, int'(fd), 1);
    endtask

    task automatic wait_reads(input string tag, input int n);
        for (int i = 0; i < 300 && (reads - rb) < n; i++) begin
            @(posedge clk); #1;
        end
        chki(tag, reads - rb, n);
    endtask

    task automatic end_frame(input string tag);
        fs = 1'b0;
        @(posedge clk); #1;
        chki(tag, int'(fd), 0);
        wr_ptr = rd_ptr;
    endtask

    initial begin
        rst = 1'b1; fs = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chki("rst_fd", int'(fd), 0);
        chki("rst_err", int'(err), 0);
        chki("rst_code", int'(err_code), 0);
        chki("rst_upd", int'(cmd_upd), 0);
        chki("rst_rxen", int'(bus.fifoc_rxen), 0);
        chk("rst_regs", cmd_regs, 72'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Good frame, FIFO never empty
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push_payload(8'h01, 8'h2D);
        fs = 1'b1;
        wait_fd("a_fd");
        @(posedge clk); #1;
        chki("a_upd", upd_cnt - ub, 1);
        chk("a_regs", cmd_regs, 72'h09_08_07_06_05_04_03_02_01);
        chki("a_err", int'(err), 0);
        chki("a_code", int'(err_code), 0);
        chki("a_reads", reads - rb, 12);
        chki("a_lat", fd_cyc - last_rd_cyc, 2);
        end_frame("a_fd_low");

        // Bad checksum
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push_payload(8'h01, 8'h2E);
        fs = 1'b1;
        wait_fd("b_fd");
        @(posedge clk); #1;
        chki("b_err", int'(err), 1);
        chki("b_code", int'(err_code), 2);
        chki("b_upd", upd_cnt - ub, 0);
        chk("b_regs", cmd_regs, 72'h09_08_07_06_05_04_03_02_01);
        chki("b_reads", reads - rb, 12);
        end_frame("b_fd_low");

        // Header mismatch: no reads beyond the failing byte
        rb = reads;
        push(8'h55); push(8'hAB); push_payload(8'h01, 8'h2D);
        fs = 1'b1;
        wait_fd("c_fd");
        @(posedge clk); #1;
        chki("c_code", int'(err_code), 1);
        chki("c_err", int'(err), 1);
        chki("c_lat", fd_cyc - last_rd_cyc, 2);
        repeat (5) @(posedge clk);
        #1;
        chki("c_reads", reads - rb, 2);
        end_frame("c_fd_low");

        // 10-cycle gap after the 5th byte stays within TIMEOUT
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push(8'h11); push(8'h12); push(8'h13);
        fs = 1'b1;
        wait_reads("d_reads5", 5);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) push(8'h14 + 8'(i));
        push(8'hBD);
        wait_fd("d_fd");
        @(posedge clk); #1;
        chki("d_code", int'(err_code), 0);
        chki("d_upd", upd_cnt - ub, 1);
        chk("d_regs", cmd_regs, 72'h19_18_17_16_15_14_13_12_11);
        end_frame("d_fd_low");

        // 16-cycle gap hits TIMEOUT
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push(8'h21); push(8'h22); push(8'h23);
        fs = 1'b1;
        wait_reads("e_reads5", 5);
        @(posedge clk);
        repeat (16) @(posedge clk);
        #1;
        chki("e_fd", int'(fd), 1);
        chki("e_code", int'(err_code), 3);
        chki("e_err", int'(err), 1);
        chk("e_regs", cmd_regs, 72'h19_18_17_16_15_14_13_12_11);
        @(posedge clk); #1;
        chki("e_upd", upd_cnt - ub, 0);
        chki("e_reads", reads - rb, 5);
        end_frame("e_fd_low");

        // Reset after the 7th byte, then a fresh frame with fs held
        rb = reads;
        push(8'h55); push(8'hAA); push(8'h31); push(8'h32);
        push(8'h33); push(8'h34); push(8'h35);
        fs = 1'b1;
        wait_reads("f_reads7", 7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("f_rst_regs", cmd_regs, 72'h0);
        chki("f_rst_fd", int'(fd), 0);
        rst = 1'b0;
        wr_ptr = rd_ptr;
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push_payload(8'h0A, 8'h7E);
        wait_fd("f_fd");
        @(posedge clk); #1;
        chk("f_regs", cmd_regs, 72'h12_11_10_0F_0E_0D_0C_0B_0A);
        chki("f_upd", upd_cnt - ub, 1);
        chki("f_err", int'(err), 0);
        chki("f_reads", reads - rb, 12);

        // fs held after DONE: fd stays, no new reads; then a new frame
        rb = reads;
        repeat (20) @(posedge clk);
        #1;
        chki("g_fd_hold", int'(fd), 1);
        chki("g_no_reads", reads - rb, 0);
        end_frame("g_fd_low");
        rb = reads; ub = upd_cnt;
        push(8'h55); push(8'hAA); push_payload(8'h01, 8'h2D);
        fs = 1'b1;
        wait_fd("g_fd");
        @(posedge clk); #1;
        chk("g_regs", cmd_regs, 72'h09_08_07_06_05_04_03_02_01);
        chki("g_upd", upd_cnt - ub, 1);
        end_frame("g_fd_low2");

        chki("rxen_while_empty", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
